cv32e40p_tb_ctrl_periph: RTL and testbench

- Memory-mapped testbench control peripheral inside cv32e40p_tb_subsystem, on the core's data bus.
- Converts firmware writes into the tests_passed_o, tests_failed_o, exit_valid_o and exit_value_o signals consumed by tb_top.
- Buffers stdout characters in a FIFO drained by a host monitor, and exposes a free-running cycle counter.
- Status outputs assert only after all buffered characters have drained.

---
 rtl/cv32e40p_tb_ctrl_periph.sv | 232 +++++++++++++++++++++++
 tb/tb_cv32e40p_tb_ctrl_periph.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_tb_ctrl_periph.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cv32e40p_tb_ctrl_periph
// Description : Memory-mapped testbench control peripheral. Turns firmware
//               writes into pass/fail/exit status for tb_top, buffers stdout
//               characters in a FIFO drained by the host monitor, and exposes
//               a free-running 64-bit cycle counter. Status outputs assert
//               only once every buffered character has been drained.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_tb_ctrl_periph #(
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] PASS_MAGIC = 32'd123456789
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    input  logic        sel_i,
    output logic        char_valid_o,
    output logic [7:0]  char_o,
    input  logic        char_ready_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] OFF_PRINT  = 3'd0;
    localparam logic [2:0] OFF_EXIT   = 3'd1;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_CYC_LO = 3'd3;
    localparam logic [2:0] OFF_CYC_HI = 3'd4;
    localparam logic [2:0] OFF_LEVEL  = 3'd5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                rvalid_q;
    logic [31:0]         rdata_q;
    logic [63:0]         cycle_q;
    logic [31:0]         cyc_hi_shadow_q;
    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wptr_q, rptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [7:0]          last_char_q;
    logic                pass_q, fail_q, exit_q;
    logic [31:0]         exit_val_q;

    logic [2:0]          w_off;
    logic                w_full;
    logic                w_empty;
    logic                w_print_wr;
    logic                w_push;
    logic                w_pop;
    logic                w_ctl_wr;
    logic                w_exit_wr;
    logic                w_status_wr;
    logic                w_any_pend;
    logic                w_done;
    logic [31:0]         w_rdata;
    logic                w_unused_addr;

    // Only the word offset within the window matters; the subsystem has
    // already decoded the window against BASE_ADDR and drives sel_i.
    assign w_unused_addr = ^{data_addr_i[31:5] ^ BASE_ADDR[31:5], data_addr_i[1:0]};

    assign w_off      = data_addr_i[4:2];
    assign w_full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign w_empty    = (count_q == '0);
    assign w_print_wr = data_we_i & (w_off == OFF_PRINT);

    // A PRINT write into a full FIFO is held off until a pop frees a slot.
    assign data_gnt_o = data_req_i & sel_i & ~(w_print_wr & w_full);

    assign w_push      = data_gnt_o & w_print_wr & data_be_i[0];
    assign w_pop       = ~w_empty & char_ready_i;
    assign w_ctl_wr    = data_gnt_o & data_we_i & (data_be_i == 4'hF) & (state_q != ST_DONE);
    assign w_exit_wr   = w_ctl_wr & (w_off == OFF_EXIT);
    assign w_status_wr = w_ctl_wr & (w_off == OFF_STATUS);
    assign w_any_pend  = pass_q | fail_q | exit_q | w_exit_wr | w_status_wr;
    assign w_done      = (state_q == ST_DONE);

    // Read data multiplexer, evaluated in the grant cycle.
    always_comb begin
        w_rdata = 32'h0;
        case (w_off)
            OFF_CYC_LO: w_rdata = cycle_q[31:0];
            OFF_CYC_HI: w_rdata = cyc_hi_shadow_q;
            OFF_LEVEL:  w_rdata = 32'(count_q);
            3'd6, 3'd7: w_rdata = 32'hDEAD_BEEF;
            default:    w_rdata = 32'h0;
        endcase
    end

    // One response pulse per grant; read data is zero outside read responses.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            rvalid_q <= data_gnt_o;
            rdata_q  <= (data_gnt_o & ~data_we_i) ? w_rdata : 32'h0;
        end
    end

    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;

    // Free-running counter; a CYCLE_LO read freezes the high word so the
    // following CYCLE_HI read forms a coherent 64-bit pair.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cycle_q         <= 64'h0;
            cyc_hi_shadow_q <= 32'h0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (data_gnt_o && !data_we_i && (w_off == OFF_CYC_LO)) begin
                cyc_hi_shadow_q <= cycle_q[63:32];
            end
        end
    end

    // FIFO storage needs no reset: it is only observed through valid entries.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wptr_q] <= data_wdata_i[7:0];
        end
    end

    // FIFO pointers, occupancy and the byte shown while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            last_char_q <= 8'h0;
        end else begin
            if (w_push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rptr_q      <= rptr_q + PTR_W'(1);
                last_char_q <= mem_q[rptr_q];
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign char_valid_o = ~w_empty;
    assign char_o       = w_empty ? last_char_q : mem_q[rptr_q];

    // Pending completion flags and exit code; frozen once DONE is reached.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            exit_q     <= 1'b0;
            exit_val_q <= 32'h0;
        end else begin
            if (w_exit_wr) begin
                exit_q     <= 1'b1;
                exit_val_q <= data_wdata_i;
            end
            if (w_status_wr) begin
                if (data_wdata_i == PASS_MAGIC) begin
                    pass_q <= 1'b1;
                end else begin
                    fail_q <= 1'b1;
                end
            end
        end
    end

    // Completion state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Completion sequencing: wait for a pending flag, then for stdout to drain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (w_any_pend) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_empty && !w_push) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign tests_passed_o = w_done & pass_q;
    assign tests_failed_o = w_done & fail_q;
    assign exit_valid_o   = w_done & exit_q;
    assign exit_value_o   = w_done ? exit_val_q : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_tb_ctrl_periph.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_tb_ctrl_periph
// Description : Self-checking bench for cv32e40p_tb_ctrl_periph. A queue-based
//               reference model is compared against the DUT every cycle, with
//               directed scenarios pinned by literal expectations followed by
//               a randomized traffic phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_tb_ctrl_periph;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam logic [31:0] MAGIC = 32'd123456789;

    logic        clk    = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req    = 1'b0;
    logic        sel    = 1'b0;
    logic        we     = 1'b0;
    logic        ready  = 1'b0;
    logic [31:0] addr   = 32'h0;
    logic [31:0] wdata  = 32'h0;
    logic [3:0]  be     = 4'h0;

    logic        data_gnt_o, data_rvalid_o, char_valid_o;
    logic        tests_passed_o, tests_failed_o, exit_valid_o;
    logic [31:0] data_rdata_o, exit_value_o;
    logic [7:0]  char_o;

    cv32e40p_tb_ctrl_periph #(
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(DEPTH),
        .PASS_MAGIC(MAGIC)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .data_req_i    (req),
        .data_gnt_o    (data_gnt_o),
        .data_addr_i   (addr),
        .data_we_i     (we),
        .data_be_i     (be),
        .data_wdata_i  (wdata),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .sel_i         (sel),
        .char_valid_o  (char_valid_o),
        .char_o        (char_o),
        .char_ready_i  (ready),
        .tests_passed_o(tests_passed_o),
        .tests_failed_o(tests_failed_o),
        .exit_valid_o  (exit_valid_o),
        .exit_value_o  (exit_value_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: values the DUT should show after the latest edge.
    // ------------------------------------------------------------------
    logic        m_rvalid  = 1'b0;
    logic [31:0] m_rdata   = 32'h0;
    logic [63:0] m_cyc     = 64'h0;
    logic [31:0] m_shadow  = 32'h0;
    logic [7:0]  m_q[$];
    logic [7:0]  m_last    = 8'h0;
    logic        m_pass    = 1'b0;
    logic        m_fail    = 1'b0;
    logic        m_exit    = 1'b0;
    logic [31:0] m_exitval = 32'h0;
    logic        m_drain   = 1'b0;
    logic        m_done    = 1'b0;
    logic [7:0]  popped[$];

    logic [2:0]  e_off;
    logic        e_gnt, e_cv, e_push, e_pop, e_wr_ok, e_to_done;
    logic [7:0]  e_co;
    logic [31:0] e_rd;

    initial begin
        forever begin
            @(negedge clk);
            e_off = addr[4:2];
            e_gnt = req && sel && !(we && e_off == 3'd0 && m_q.size() == DEPTH);
            e_cv  = (m_q.size() != 0);
            e_co  = e_cv ? m_q[0] : m_last;
            chk("gnt",         64'(data_gnt_o),     64'(e_gnt));
            chk("rvalid",      64'(data_rvalid_o),  64'(m_rvalid));
            chk("rdata",       64'(data_rdata_o),   64'(m_rdata));
            chk("char_valid",  64'(char_valid_o),   64'(e_cv));
            chk("char",        64'(char_o),         64'(e_co));
            chk("passed",      64'(tests_passed_o), 64'(m_done & m_pass));
            chk("failed",      64'(tests_failed_o), 64'(m_done & m_fail));
            chk("exit_valid",  64'(exit_valid_o),   64'(m_done & m_exit));
            chk("exit_value",  64'(exit_value_o),   64'(m_done ? m_exitval : 32'h0));
            if (char_valid_o && ready) popped.push_back(char_o);

            // Advance the model across the coming rising edge.
            if (!rst_ni) begin
                m_q.delete();
                m_rvalid = 1'b0; m_rdata = 32'h0; m_cyc = 64'h0; m_shadow = 32'h0;
                m_last = 8'h0; m_pass = 1'b0; m_fail = 1'b0; m_exit = 1'b0;
                m_exitval = 32'h0; m_drain = 1'b0; m_done = 1'b0;
            end else begin
                e_push    = e_gnt && we && e_off == 3'd0 && be[0];
                e_pop     = e_cv && ready;
                e_wr_ok   = e_gnt && we && be == 4'hF && !m_done;
                e_to_done = m_drain && m_q.size() == 0 && !e_push;
                e_rd      = 32'h0;
                if (e_gnt && !we) begin
                    case (e_off)
                        3'd3:       e_rd = m_cyc[31:0];
                        3'd4:       e_rd = m_shadow;
                        3'd5:       e_rd = 32'(m_q.size());
                        3'd6, 3'd7: e_rd = 32'hDEAD_BEEF;
                        default:    e_rd = 32'h0;
                    endcase
                    if (e_off == 3'd3) m_shadow = m_cyc[63:32];
                end
                if (e_wr_ok && e_off == 3'd1) begin
                    m_exit = 1'b1; m_exitval = wdata;
                end
                if (e_wr_ok && e_off == 3'd2) begin
                    if (wdata == MAGIC) m_pass = 1'b1;
                    else                m_fail = 1'b1;
                end
                if (!m_drain && !m_done && (m_pass || m_fail || m_exit)) m_drain = 1'b1;
                if (e_to_done) begin
                    m_drain = 1'b0; m_done = 1'b1;
                end
                if (e_pop)  m_last = m_q.pop_front();
                if (e_push) m_q.push_back(wdata[7:0]);
                m_rvalid = e_gnt;
                m_rdata  = e_rd;
                m_cyc    = m_cyc + 64'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers; all are entered and left just after a rising edge.
    // ------------------------------------------------------------------
    task automatic bus(input logic w, input logic [2:0] off, input logic [3:0] b,
                       input logic [31:0] d, output logic [31:0] rd);
        logic got;
        got = 1'b0;
        req = 1'b1; sel = 1'b1; we = w; be = b; wdata = d;
        addr = BASE + {27'h0, off, 2'b00};
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (data_gnt_o) got = 1'b1;
            @(posedge clk); #1;
        end
        chk("gnt_within_budget", 64'(got), 64'd1);
        req = 1'b0; sel = 1'b0; we = 1'b0;
        @(negedge clk);
        chk("rvalid_after_gnt", 64'(data_rvalid_o), 64'(got));
        rd = data_rdata_o;
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        rst_ni = 1'b0; req = 1'b0; sel = 1'b0; we = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    task automatic wait_empty(input string nm);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (!char_valid_o) found = 1'b1;
        end
        chk(nm, 64'(found), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;
    logic        g_last;
    int          rdy_bias;
    logic [31:0] rnd;

    initial begin
        // Reset and first CYCLE_LO read ten cycles after release.
        do_reset(4);
        @(negedge clk);
        chk("rst_rvalid",  64'(data_rvalid_o),  64'd0);
        chk("rst_charv",   64'(char_valid_o),   64'd0);
        chk("rst_passed",  64'(tests_passed_o), 64'd0);
        chk("rst_exit",    64'(exit_valid_o),   64'd0);
        repeat (10) @(posedge clk);
        #1;
        bus(1'b0, 3'd3, 4'hF, 32'h0, rd);
        chk("cycle_lo_at_10", 64'(rd), 64'd10);

        // "Hi\n" with the host always ready.
        ready = 1'b1;
        popped.delete();
        bus(1'b1, 3'd0, 4'hF, 32'h48, rd);
        bus(1'b1, 3'd0, 4'hF, 32'h69, rd);
        bus(1'b1, 3'd0, 4'hF, 32'h0A, rd);
        repeat (3) @(posedge clk);
        #1;
        chk("hi_count", 64'(popped.size()), 64'd3);
        if (popped.size() == 3) begin
            chk("hi_0", 64'(popped[0]), 64'h48);
            chk("hi_1", 64'(popped[1]), 64'h69);
            chk("hi_2", 64'(popped[2]), 64'h0A);
        end

        // Fill the FIFO, stall a 17th PRINT, free one slot.
        ready = 1'b0;
        for (int i = 0; i < 16; i++) bus(1'b1, 3'd0, 4'hF, 32'h30 + i, rd);
        bus(1'b0, 3'd5, 4'hF, 32'h0, rd);
        chk("level_full", 64'(rd), 64'd16);
        req = 1'b1; sel = 1'b1; we = 1'b1; be = 4'hF; wdata = 32'h5A;
        addr = BASE;
        @(negedge clk); chk("stall_gnt0", 64'(data_gnt_o), 64'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("stall_gnt1", 64'(data_gnt_o), 64'd0);
        @(posedge clk); #1 ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        @(negedge clk); chk("stall_released", 64'(data_gnt_o), 64'd1);
        @(posedge clk); #1 req = 1'b0; sel = 1'b0; we = 1'b0;
        @(negedge clk); chk("stall_rvalid", 64'(data_rvalid_o), 64'd1);
        @(posedge clk); #1;
        bus(1'b0, 3'd5, 4'hF, 32'h0, rd);
        chk("level_after", 64'(rd), 64'd16);
        bus(1'b0, 3'd6, 4'hF, 32'h0, rd);
        chk("unmapped_read", 64'(rd), 64'hDEAD_BEEF);
        ready = 1'b1;
        wait_empty("drain_full");
        @(posedge clk); #1;

        // EXIT waits for stdout to drain.
        ready = 1'b0;
        for (int i = 0; i < 5; i++) bus(1'b1, 3'd0, 4'hF, 32'h61 + i, rd);
        bus(1'b1, 3'd1, 4'hF, 32'h0, rd);
        repeat (4) @(posedge clk);
        @(negedge clk); chk("exit_held", 64'(exit_valid_o), 64'd0);
        @(posedge clk); #1 ready = 1'b1;
        wait_empty("drain_exit");
        chk("exit_pre", 64'(exit_valid_o), 64'd0);
        @(negedge clk);
        chk("exit_valid_done", 64'(exit_valid_o), 64'd1);
        chk("exit_value_done", 64'(exit_value_o), 64'd0);
        @(posedge clk); #1;
        bus(1'b1, 3'd1, 4'hF, 32'h5, rd);
        bus(1'b1, 3'd2, 4'hF, MAGIC, rd);
        @(negedge clk);
        chk("done_ignores_exit",   64'(exit_value_o),   64'd0);
        chk("done_ignores_status", 64'(tests_passed_o), 64'd0);
        @(posedge clk); #1;

        // TEST_STATUS pass, fail, and partial byte enables.
        do_reset(2);
        bus(1'b1, 3'd2, 4'hF, MAGIC, rd);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pass_passed", 64'(tests_passed_o), 64'd1);
        chk("pass_failed", 64'(tests_failed_o), 64'd0);
        @(posedge clk); #1;
        do_reset(2);
        bus(1'b1, 3'd2, 4'hF, 32'd7, rd);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("fail_failed", 64'(tests_failed_o), 64'd1);
        chk("fail_passed", 64'(tests_passed_o), 64'd0);
        @(posedge clk); #1;
        do_reset(2);
        bus(1'b1, 3'd2, 4'h7, MAGIC, rd);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("partial_passed", 64'(tests_passed_o), 64'd0);
        chk("partial_failed", 64'(tests_failed_o), 64'd0);
        @(posedge clk); #1;
        bus(1'b1, 3'd2, 4'hF, MAGIC, rd);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("full_after_partial", 64'(tests_passed_o), 64'd1);
        @(posedge clk); #1;

        // Coherent 64-bit read across the 32-bit rollover.
        do_reset(2);
        force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
        m_cyc = 64'h0000_0000_FFFF_FFFF;
        #1 release dut.cycle_q;
        bus(1'b0, 3'd3, 4'hF, 32'h0, rd);
        chk("roll_lo", 64'(rd), 64'hFFFF_FFFF);
        bus(1'b0, 3'd4, 4'hF, 32'h0, rd);
        chk("roll_hi_shadow", 64'(rd), 64'd0);
        bus(1'b0, 3'd3, 4'hF, 32'h0, rd);
        bus(1'b0, 3'd4, 4'hF, 32'h0, rd);
        chk("roll_hi_after", 64'(rd), 64'd1);

        // Reset in the middle of DRAIN with a read in flight.
        do_reset(2);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) bus(1'b1, 3'd0, 4'hF, 32'h41 + i, rd);
        bus(1'b1, 3'd1, 4'hF, 32'd3, rd);
        rst_ni = 1'b0; req = 1'b1; sel = 1'b1; we = 1'b0; be = 4'hF;
        addr = BASE + 32'h14;
        @(negedge clk);
        chk("mid_charv_before", 64'(char_valid_o), 64'd1);
        chk("mid_gnt", 64'(data_gnt_o), 64'd1);
        @(posedge clk); #1 rst_ni = 1'b1; req = 1'b0; sel = 1'b0;
        @(negedge clk);
        chk("mid_rvalid", 64'(data_rvalid_o), 64'd0);
        chk("mid_charv",  64'(char_valid_o),  64'd0);
        chk("mid_char",   64'(char_o),        64'd0);
        chk("mid_exit",   64'(exit_valid_o),  64'd0);
        @(posedge clk); #1;

        // Randomized traffic against the model.
        g_last = 1'b0;
        rdy_bias = 2;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) rdy_bias = $urandom_range(0, 4);
            if (!(req && !g_last)) begin
                rnd   = $urandom;
                req   = ($urandom_range(0, 3) != 0);
                sel   = ($urandom_range(0, 7) != 0);
                we    = rnd[0];
                be    = ($urandom_range(0, 3) == 0) ? rnd[4:1] : 4'hF;
                wdata = rnd[5] ? MAGIC : $urandom;
                e_off = (rnd[9:6] < 4'd8) ? 3'd0 : rnd[8:6];
                addr  = {rnd[31:27], 22'h0, e_off, rnd[11:10]};
            end
            ready  = ($urandom_range(0, 3) < rdy_bias);
            rst_ni = ($urandom_range(0, 299) != 0);
            @(negedge clk);
            g_last = data_gnt_o;
            @(posedge clk); #1;
        end
        req = 1'b0; sel = 1'b0; rst_ni = 1'b1;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
